packet_rr_arbiter: RTL and testbench

- Parametrised N-input wormhole output-port arbiter for the mesh router, one instance per output port.
- Grants one input at a time. Inputs are served in round-robin order, and the last served input has the lowest priority.
- Holds a grant for a whole packet, until the tail flit transfers or the flit count from the header length is exhausted.
- Adds flit-accurate counting (advances only on transferred flits), a stall watchdog, and a generic input count.

---
 rtl/packet_rr_arbiter_pkg.sv | 20 ++
 rtl/packet_rr_arbiter_rr_pick.sv | 31 +++
 rtl/packet_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_packet_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_rr_arbiter_pkg.sv
// Shared flit type codes, mesh port indices and arbiter state encoding.
// Pure declarations: no latency and no backpressure of its own.
package packet_rr_arbiter_pkg;

  localparam logic [2:0] FT_HEADER = 3'b001;
  localparam logic [2:0] FT_BODY   = 3'b010;
  localparam logic [2:0] FT_TAIL   = 3'b100;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

endpackage

// File: rtl/packet_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
// Zero latency; no flow control, the caller decides when the result is used.
module rr_pick #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_winner,
  output logic              o_found
);

  // Pass one covers ptr..NUM_IN-1; pass two then wraps to the low indices.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!o_found && (i >= int'(i_ptr)) && i_req[i]) begin
        o_winner[i] = 1'b1;
        o_found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (!o_found && i_req[i]) begin
        o_winner[i] = 1'b1;
        o_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_rr_arbiter.sv
// Wormhole output-port arbiter: round-robin grant held for a whole packet.
// Grant 1 cycle after req; holds while fire is low, released by tail/count/watchdog.
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int NUM_IN    = 5,
  parameter int LEN_W     = 12,
  parameter int FT_W      = 3,
  parameter int STALL_MAX = 64,
  parameter int IDX_W     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       req,
  input  logic [NUM_IN*FT_W-1:0]  flit_type,
  input  logic [NUM_IN*LEN_W-1:0] length,
  input  logic                    fire,
  output logic [NUM_IN-1:0]       grant,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    idle,
  output logic                    stall_abort
);

  localparam int STALL_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;

  arb_state_e          r_state;
  logic [NUM_IN-1:0]   r_grant;
  logic [IDX_W-1:0]    r_grant_idx;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_idle;
  logic                r_stall_abort;
  logic [LEN_W-1:0]    r_remaining;
  logic [STALL_W-1:0]  r_stall_cnt;

  logic [FT_W-1:0]     w_gnt_ft;
  logic [LEN_W-1:0]    w_gnt_len;
  logic                w_gnt_req;
  logic                w_is_hdr;
  logic                w_is_tail;
  logic                w_pkt_done;
  logic                w_stall_expire;
  logic                w_release;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [IDX_W-1:0]    w_arb_ptr;
  logic [NUM_IN-1:0]   w_win;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_found;

  always_comb begin
    w_gnt_ft  = '0;
    w_gnt_len = '0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (r_grant[i]) begin
        w_gnt_ft  = flit_type[i*FT_W +: FT_W];
        w_gnt_len = length[i*LEN_W +: LEN_W];
      end
      if (w_win[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_gnt_req  = |(req & r_grant);
  assign w_is_hdr   = (w_gnt_ft == FT_W'(FT_HEADER));
  assign w_is_tail  = (w_gnt_ft == FT_W'(FT_TAIL));
  assign w_pkt_done = fire && (w_is_tail ||
                               (w_is_hdr && (w_gnt_len <= LEN_W'(1))) ||
                               (!w_is_hdr && (r_remaining == LEN_W'(1))));
  // Fires on the STALL_MAX-th consecutive starved cycle, so the grant moves on that edge.
  assign w_stall_expire = (STALL_MAX > 0) && (r_state == ST_LOCKED) && !w_gnt_req && !fire &&
                          (int'(r_stall_cnt) == STALL_MAX - 1);
  assign w_release  = (r_state == ST_LOCKED) && (w_pkt_done || w_stall_expire);
  assign w_next_ptr = (r_grant_idx == IDX_W'(NUM_IN - 1)) ? '0 : r_grant_idx + 1'b1;
  assign w_arb_ptr  = (r_state == ST_LOCKED) ? w_next_ptr : r_ptr;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (w_arb_ptr),
    .o_winner (w_win),
    .o_found  (w_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_idx   <= '0;
      r_ptr         <= '0;
      r_idle        <= 1'b1;
      r_stall_abort <= 1'b0;
      r_remaining   <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_stall_abort <= w_stall_expire;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant     <= w_win;
            r_grant_idx <= w_win_idx;
            r_idle      <= 1'b0;
            r_remaining <= '0;
            r_stall_cnt <= '0;
            r_state     <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_release) begin
            r_ptr       <= w_next_ptr;
            r_remaining <= '0;
            r_stall_cnt <= '0;
            if (w_found) begin
              r_grant     <= w_win;
              r_grant_idx <= w_win_idx;
            end else begin
              r_grant     <= '0;
              r_grant_idx <= '0;
              r_idle      <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end else begin
            if (fire) begin
              if (w_is_hdr)
                r_remaining <= w_gnt_len - 1'b1;
              else if (r_remaining != '0)
                r_remaining <= r_remaining - 1'b1;
            end
            if (fire || w_gnt_req)
              r_stall_cnt <= '0;
            else if (STALL_MAX > 0)
              r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign idle        = r_idle;
  assign stall_abort = r_stall_abort;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: vector table, directed corner sequences, random vs reference model.
module tb_packet_rr_arbiter;
  import packet_rr_arbiter_pkg::*;

  localparam int NI = 5;
  localparam int LW = 12;
  localparam int FW = 3;
  localparam int SM = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   req;
  logic [NI*FW-1:0] flit_type;
  logic [NI*LW-1:0] length;
  logic            fire;
  logic [NI-1:0]   grant;
  logic [IW-1:0]   grant_idx;
  logic            idle;
  logic            stall_abort;

  logic [FW-1:0]   ft_a  [NI];
  logic [LW-1:0]   len_a [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      flit_type[i*FW +: FW] = ft_a[i];
      length[i*LW +: LW]    = len_a[i];
    end
  end

  packet_rr_arbiter #(
    .NUM_IN(NI), .LEN_W(LW), .FT_W(FW), .STALL_MAX(SM), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .flit_type(flit_type), .length(length),
    .fire(fire), .grant(grant), .grant_idx(grant_idx), .idle(idle),
    .stall_abort(stall_abort)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [2:0]  ft;
    logic [11:0] len;
    logic        fire;
    logic [4:0]  eg;
    int          eidx;
    logic        eidle;
    logic        eab;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [2:0] t,
                              input int l, input logic f, input logic [4:0] eg,
                              input int ei, input logic eid, input logic eab);
    vec_t v;
    v.rst = r; v.req = rq; v.ft = t; v.len = 12'(l); v.fire = f;
    v.eg = eg; v.eidx = ei; v.eidle = eid; v.eab = eab;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [2:0] t, input int l);
    for (int i = 0; i < NI; i++) begin
      ft_a[i]  = t;
      len_a[i] = 12'(l);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; fire = 1'b0; set_all(FT_BODY, 0);
    tick();
    rst = 1'b0;
  endtask

  // Reference model: owner index (-1 = idle), priority start, flits left, starved cycles.
  int m_own = -1;
  int m_ptr = 0;
  int m_rem = 0;
  int m_stall = 0;
  int m_ab = 0;

  function automatic int rr(input logic [4:0] r, input int p);
    for (int k = 0; k < NI; k++) begin
      int j;
      j = (p + k) % NI;
      if (r[j[2:0]]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g; int l; logic [2:0] t; bit rel;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_rem = 0; m_stall = 0; m_ab = 0;
    end else if (m_own < 0) begin
      m_ab = 0; m_own = rr(req, m_ptr); m_rem = 0; m_stall = 0;
    end else begin
      g = m_own; t = ft_a[g[2:0]]; l = int'(len_a[g[2:0]]); rel = 0; m_ab = 0;
      if (fire) begin
        m_stall = 0;
        if (t == FT_HEADER) begin
          if (l <= 1) rel = 1; else m_rem = l - 1;
        end else if (t == FT_TAIL || m_rem == 1) rel = 1;
        else if (m_rem > 0) m_rem--;
      end else if (req[g[2:0]]) begin
        m_stall = 0;
      end else begin
        m_stall++;
        if (m_stall == SM) begin rel = 1; m_ab = 1; end
      end
      if (rel) begin
        m_ptr = (g + 1) % NI; m_own = rr(req, m_ptr); m_rem = 0; m_stall = 0;
      end
    end
  endtask

  logic [2:0] seq_t [4];

  initial begin
    rst = 1'b1; req = '0; fire = 1'b0; set_all(FT_BODY, 0);

    // Single packet on input 0, then full rotation, then reset mid-packet.
    tbl.push_back(mk(1, 5'b00000, FT_HEADER, 0, 0, 5'b00000, 0, 1, 0));
    tbl.push_back(mk(0, 5'b00001, FT_HEADER, 3, 0, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00001, FT_HEADER, 3, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00001, FT_BODY,   3, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, FT_BODY,   3, 1, 5'b00000, 0, 1, 0));
    tbl.push_back(mk(0, 5'b00000, FT_HEADER, 3, 1, 5'b00000, 0, 1, 0));
    tbl.push_back(mk(1, 5'b11111, FT_HEADER, 2, 0, 5'b00000, 0, 1, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 0, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_BODY,   2, 1, 5'b00010, 1, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 1, 5'b00010, 1, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_BODY,   2, 1, 5'b00100, 2, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 1, 5'b00100, 2, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_BODY,   2, 1, 5'b01000, 3, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 1, 5'b01000, 3, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_BODY,   2, 1, 5'b10000, 4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 2, 1, 5'b10000, 4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_BODY,   2, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 5, 1, 5'b00001, 0, 0, 0));
    tbl.push_back(mk(1, 5'b11111, FT_BODY,   5, 1, 5'b00000, 0, 1, 0));
    tbl.push_back(mk(0, 5'b11111, FT_HEADER, 5, 0, 5'b00001, 0, 0, 0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; req = tbl[k].req; fire = tbl[k].fire;
      set_all(tbl[k].ft, int'(tbl[k].len));
      tick();
      chk($sformatf("vec%0d grant", k), int'(grant), int'(tbl[k].eg));
      chk($sformatf("vec%0d grant_idx", k), int'(grant_idx), tbl[k].eidx);
      chk($sformatf("vec%0d idle", k), int'(idle), int'(tbl[k].eidle));
      chk($sformatf("vec%0d stall_abort", k), int'(stall_abort), int'(tbl[k].eab));
    end

    // Input 2, length 8, tail on 4th flit; next grant's count starts fresh.
    do_reset();
    req = 5'b00100; ft_a[2] = FT_HEADER; len_a[2] = 12'd8;
    tick(); chk("tail grant2", int'(grant), 4);
    fire = 1'b1;
    tick(); chk("tail hdr", int'(grant), 4);
    ft_a[2] = FT_BODY;
    tick(); chk("tail body1", int'(grant), 4);
    tick(); chk("tail body2", int'(grant), 4);
    ft_a[2] = FT_TAIL; req = 5'b00101;
    tick(); chk("tail release grant", int'(grant), 1);
    chk("tail release idx", int'(grant_idx), 0);
    ft_a[0] = FT_HEADER; len_a[0] = 12'd2; req = 5'b00001;
    tick(); chk("next pkt hdr", int'(grant), 1);
    ft_a[0] = FT_BODY; req = 5'b00000;
    tick(); chk("next pkt done idle", int'(idle), 1);
    fire = 1'b0;

    // Input 1 locked, others requesting, fire every 3rd cycle: no pre-emption.
    do_reset();
    seq_t[0] = FT_HEADER; seq_t[1] = FT_BODY; seq_t[2] = FT_BODY; seq_t[3] = FT_TAIL;
    req = 5'b00010; ft_a[1] = FT_HEADER; len_a[1] = 12'd4;
    tick(); chk("gap grant1", int'(grant), 2);
    req = 5'b11111;
    for (int f = 0; f < 4; f++) begin
      fire = 1'b0;
      tick(); chk($sformatf("gap hold%0d a", f), int'(grant), 2);
      tick(); chk($sformatf("gap hold%0d b", f), int'(grant), 2);
      ft_a[1] = seq_t[f]; fire = 1'b1;
      tick();
      chk($sformatf("gap fire%0d", f), int'(grant), (f < 3) ? 2 : 4);
    end
    fire = 1'b0;

    // Watchdog: input 3 starves for STALL_MAX cycles, grant moves to input 4.
    do_reset();
    req = 5'b01000; ft_a[3] = FT_HEADER; len_a[3] = 12'd5;
    tick(); chk("wd grant3", int'(grant), 8);
    fire = 1'b1;
    tick(); chk("wd hdr", int'(grant), 8);
    fire = 1'b0; req = 5'b10001;
    for (int c = 1; c < SM; c++) begin
      tick();
      chk($sformatf("wd starve%0d grant", c), int'(grant), 8);
      chk($sformatf("wd starve%0d abort", c), int'(stall_abort), 0);
    end
    tick();
    chk("wd abort pulse", int'(stall_abort), 1);
    chk("wd new grant", int'(grant), 16);
    chk("wd new idx", int'(grant_idx), 4);
    tick(); chk("wd abort clear", int'(stall_abort), 0);

    // Random traffic against the reference model.
    rst = 1'b1; tick(); model_step(); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] codes [5];
      codes[0] = FT_HEADER; codes[1] = FT_BODY; codes[2] = FT_TAIL;
      codes[3] = 3'b000; codes[4] = 3'b111;
      rst  = ($urandom_range(0, 299) == 0);
      req  = 5'($urandom_range(0, 31));
      fire = 1'($urandom_range(0, 1));
      for (int i = 0; i < NI; i++) begin
        ft_a[i]  = codes[$urandom_range(0, 4)];
        len_a[i] = 12'($urandom_range(0, 6));
      end
      tick();
      model_step();
      chk($sformatf("rnd%0d grant", n), int'(grant), (m_own < 0) ? 0 : (1 << m_own));
      chk($sformatf("rnd%0d grant_idx", n), int'(grant_idx), (m_own < 0) ? 0 : m_own);
      chk($sformatf("rnd%0d idle", n), int'(idle), (m_own < 0) ? 1 : 0);
      chk($sformatf("rnd%0d stall_abort", n), int'(stall_abort), m_ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
